weight_stream_loader: RTL and testbench
=======================================

Name: weight_stream_loader

Overview:
- Upstream feeder of the weight memory; fills its FC and CNN external write ports.
- Accepts a 32-bit valid/ready weight stream from the DMA/host side.
- Packs each pair of beats into one 64-bit weight row (8 x 8-bit weights) and writes the row at an auto-incrementing row address.
- Address bit 15 selects the ping-pong bank, so one bank can be loaded while the array reads the other.

Parameters:
- IN_WIDTH, 32, stream beat width in bits.
- ROW_WIDTH, 64, weight row width in bits (N_DIM_ARRAY * WEIGHT_DATA_WIDTH = 8 * 8).
- ADDR_WIDTH, 16, weight memory row address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- abort  in  1  synchronous abort of a load in progress.
- mode  in  3  0 = MODE_FC, 1 = MODE_CNN; sampled at start.
- base_addr  in  ADDR_WIDTH  first row address; sampled at start.
- num_rows  in  ADDR_WIDTH  number of rows to write; sampled at start.
- s_valid  in  1  stream beat valid.
- s_data  in  IN_WIDTH  stream beat data.
- s_ready  out  1  loader can accept a beat.
- wr_en_fc_w  out  1  FC port write strobe.
- wr_addr_fc_w  out  ADDR_WIDTH  FC port write address.
- wr_data_fc_w  out  ROW_WIDTH  FC port write data.
- wr_en_cnn_w  out  1  CNN port write strobe.
- wr_addr_cnn_w  out  ADDR_WIDTH  CNN port write address.
- wr_data_cnn_w  out  ROW_WIDTH  CNN port write data.
- busy  out  1  high while in LOAD.
- done  out  1  one-cycle completion pulse.
- rows_written  out  ADDR_WIDTH  rows written in the current or last load.

Behaviour:
- Reset values: all outputs 0; state IDLE; half flag 0; internal counters 0.
- States:
  - IDLE -> LOAD on start when num_rows != 0 and mode is 0 or 1.
  - start with num_rows == 0, or with mode not 0/1: stay IDLE, no writes, done high next cycle.
  - LOAD -> IDLE on acceptance of the final high beat, or on abort.
- start while in LOAD is ignored. At start, rows_written clears to 0.
- s_ready = (state == LOAD), combinational. A handshake is s_valid && s_ready.
- Packing (half flag toggles on each handshake):
  - half = 0: beat is held in row[31:0].
  - half = 1: beat forms row[63:32]; the row write is issued.
- Write timing: registered. wr_en of the sampled-mode port is high exactly one cycle, in the cycle after the high-beat handshake.
  - In that cycle, addr = base_addr + row_index, with row_index counting 0..num_rows-1.
  - Address arithmetic is modulo 2^16; 0xFFFF wraps to 0x0000, crossing into bank 0.
  - The unselected port holds en = 0, addr = 0, data = 0.
- rows_written increments in the same cycle each write strobe is seen.
- Latency: high beat accepted at cycle t -> write strobe at t+1. Back-to-back beats give one write every 2 cycles.
- Completion: done is high in the same cycle as the final write strobe. busy drops in that cycle, and s_ready is low from that cycle onward.
- abort in LOAD:
  - Next cycle returns to IDLE; any pending low half is discarded.
  - No done pulse. rows_written holds the count already written.
  - A write strobe already registered in that cycle still completes.
- Simultaneous abort and final high-beat handshake: abort wins. The beat is consumed, no write is issued, no done.
- abort in IDLE has no effect.
- s_valid low mid-row: the low half is held indefinitely, with no timeout.
- Asynchronous reset mid-load: immediate return to IDLE and all outputs 0. The partial row is lost; rows already written remain in memory.

Test Plan:
- FC load: mode = 0, base = 0x0010, num_rows = 3, beats 0x03020100, 0x07060504, … back-to-back -> wr_en_fc_w pulses at addr 0x10, 0x11, 0x12. First data = 0x0706050403020100. done coincides with the third strobe; wr_en_cnn_w stays 0.
- CNN load into bank 1 with stalls: mode = 1, base = 0x8000, num_rows = 2, s_valid toggling every other cycle -> writes at 0x8000 and 0x8001 only on wr_en_cnn_w. Packing stays correct across stalls; rows_written = 2.
- Wrap-around: base = 0xFFFF, num_rows = 2 -> writes at 0xFFFF then 0x0000. done = 1.
- Zero length and illegal mode:
  - num_rows = 0 -> no strobes, done one cycle after start, s_ready never high.
  - mode = 2 -> same response.
- Abort: abort after 3 beats (one row written) -> state IDLE, rows_written = 1, no done, second row never written. A following start with num_rows = 1 writes correctly with a fresh low half.
- Reset mid-load: drive reset low during LOAD with half = 1 -> all outputs 0 immediately. After release, a new 1-row load produces the correct data.

Source files
------------

// File: rtl/weight_stream_loader.sv
// Weight stream loader: packs pairs of 32-bit stream beats into 64-bit weight rows
// and writes them to the FC or CNN weight-memory port at auto-incrementing row addresses.
module weight_stream_loader #(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned ROW_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_rows,
    input  logic                  s_valid,
    input  logic [IN_WIDTH-1:0]   s_data,
    output logic                  s_ready,
    output logic                  wr_en_fc_w,
    output logic [ADDR_WIDTH-1:0] wr_addr_fc_w,
    output logic [ROW_WIDTH-1:0]  wr_data_fc_w,
    output logic                  wr_en_cnn_w,
    output logic [ADDR_WIDTH-1:0] wr_addr_cnn_w,
    output logic [ROW_WIDTH-1:0]  wr_data_cnn_w,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rows_written
);

    localparam logic [2:0] MODE_FC  = 3'd0;
    localparam logic [2:0] MODE_CNN = 3'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  half_q, half_d;
    logic [IN_WIDTH-1:0]   low_q, low_d;
    logic                  cnn_q, cnn_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] num_q, num_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  wr_en_fc_q, wr_en_fc_d;
    logic [ADDR_WIDTH-1:0] wr_addr_fc_q, wr_addr_fc_d;
    logic [ROW_WIDTH-1:0]  wr_data_fc_q, wr_data_fc_d;
    logic                  wr_en_cnn_q, wr_en_cnn_d;
    logic [ADDR_WIDTH-1:0] wr_addr_cnn_q, wr_addr_cnn_d;
    logic [ROW_WIDTH-1:0]  wr_data_cnn_q, wr_data_cnn_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] rows_written_q, rows_written_d;

    logic                  handshake_c;
    logic                  mode_ok_c;
    logic                  last_row_c;
    logic [ADDR_WIDTH-1:0] row_addr_c;
    logic [ROW_WIDTH-1:0]  row_data_c;

    assign s_ready     = (state_q == ST_LOAD);
    assign handshake_c = s_valid && s_ready;
    assign mode_ok_c   = (mode == MODE_FC) || (mode == MODE_CNN);
    assign last_row_c  = (idx_q == num_q - ADDR_WIDTH'(1));
    // Address wraps modulo 2^ADDR_WIDTH, so the top bit flips banks on overflow.
    assign row_addr_c  = base_q + idx_q;
    assign row_data_c  = ROW_WIDTH'({s_data, low_q});

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        half_d         = half_q;
        low_d          = low_q;
        cnn_d          = cnn_q;
        base_d         = base_q;
        num_d          = num_q;
        idx_d          = idx_q;
        wr_en_fc_d     = 1'b0;
        wr_addr_fc_d   = '0;
        wr_data_fc_d   = '0;
        wr_en_cnn_d    = 1'b0;
        wr_addr_cnn_d  = '0;
        wr_data_cnn_d  = '0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        rows_written_d = rows_written_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rows_written_d = '0;
                    if ((num_rows != '0) && mode_ok_c) begin
                        state_d = ST_LOAD;
                        busy_d  = 1'b1;
                        cnn_d   = (mode == MODE_CNN);
                        base_d  = base_addr;
                        num_d   = num_rows;
                        idx_d   = '0;
                        half_d  = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // Abort wins over any beat in the same cycle; a pending low half is dropped.
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    half_d  = 1'b0;
                end else if (handshake_c) begin
                    if (!half_q) begin
                        low_d  = s_data;
                        half_d = 1'b1;
                    end else begin
                        half_d         = 1'b0;
                        idx_d          = idx_q + ADDR_WIDTH'(1);
                        rows_written_d = rows_written_q + ADDR_WIDTH'(1);
                        if (cnn_q) begin
                            wr_en_cnn_d   = 1'b1;
                            wr_addr_cnn_d = row_addr_c;
                            wr_data_cnn_d = row_data_c;
                        end else begin
                            wr_en_fc_d   = 1'b1;
                            wr_addr_fc_d = row_addr_c;
                            wr_data_fc_d = row_data_c;
                        end
                        if (last_row_c) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            half_q         <= 1'b0;
            low_q          <= '0;
            cnn_q          <= 1'b0;
            base_q         <= '0;
            num_q          <= '0;
            idx_q          <= '0;
            wr_en_fc_q     <= 1'b0;
            wr_addr_fc_q   <= '0;
            wr_data_fc_q   <= '0;
            wr_en_cnn_q    <= 1'b0;
            wr_addr_cnn_q  <= '0;
            wr_data_cnn_q  <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            rows_written_q <= '0;
        end else begin
            state_q        <= state_d;
            half_q         <= half_d;
            low_q          <= low_d;
            cnn_q          <= cnn_d;
            base_q         <= base_d;
            num_q          <= num_d;
            idx_q          <= idx_d;
            wr_en_fc_q     <= wr_en_fc_d;
            wr_addr_fc_q   <= wr_addr_fc_d;
            wr_data_fc_q   <= wr_data_fc_d;
            wr_en_cnn_q    <= wr_en_cnn_d;
            wr_addr_cnn_q  <= wr_addr_cnn_d;
            wr_data_cnn_q  <= wr_data_cnn_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            rows_written_q <= rows_written_d;
        end
    end

    assign wr_en_fc_w    = wr_en_fc_q;
    assign wr_addr_fc_w  = wr_addr_fc_q;
    assign wr_data_fc_w  = wr_data_fc_q;
    assign wr_en_cnn_w   = wr_en_cnn_q;
    assign wr_addr_cnn_w = wr_addr_cnn_q;
    assign wr_data_cnn_w = wr_data_cnn_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign rows_written  = rows_written_q;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Self-checking bench for weight_stream_loader: random beats and stalls, compared
// against a row-list model (row i = {beat 2i+1, beat 2i} at base+i mod 2^16).
module tb_weight_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [2:0]  mode;
    logic [15:0] base_addr;
    logic [15:0] num_rows;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        wr_en_fc_w;
    logic [15:0] wr_addr_fc_w;
    logic [63:0] wr_data_fc_w;
    logic        wr_en_cnn_w;
    logic [15:0] wr_addr_cnn_w;
    logic [63:0] wr_data_cnn_w;
    logic        busy;
    logic        done;
    logic [15:0] rows_written;

    weight_stream_loader #(.IN_WIDTH(32), .ROW_WIDTH(64), .ADDR_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .base_addr(base_addr), .num_rows(num_rows), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wr_en_fc_w(wr_en_fc_w), .wr_addr_fc_w(wr_addr_fc_w),
        .wr_data_fc_w(wr_data_fc_w), .wr_en_cnn_w(wr_en_cnn_w), .wr_addr_cnn_w(wr_addr_cnn_w),
        .wr_data_cnn_w(wr_data_cnn_w), .busy(busy), .done(done), .rows_written(rows_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cnn;
        logic [15:0] addr;
        logic [63:0] data;
        logic [15:0] rw;
        int          cyc;
    } wr_obs_t;

    wr_obs_t     obs_q[$];
    int          hi_cyc_q[$];
    int          done_cyc_q[$];
    logic [31:0] beat_q[$];
    int          cyc;
    int          start_cyc;
    int          ready_seen;
    int          bad_unsel;
    int          busy_at_done;
    int          ready_at_done;
    bit          timed_out;
    int          n_checks;
    int          n_fail;

    task automatic fill_beats(input int n_beats);
        beat_q.delete();
        for (int i = 0; i < n_beats; i++) beat_q.push_back($urandom);
    endtask

    // One clock: sample everything 1 time unit after the rising edge.
    task automatic step(input logic [2:0] m);
        @(posedge clk);
        #1;
        cyc++;
        if (s_ready) ready_seen++;
        if (wr_en_fc_w)  obs_q.push_back('{1'b0, wr_addr_fc_w, wr_data_fc_w, rows_written, cyc});
        if (wr_en_cnn_w) obs_q.push_back('{1'b1, wr_addr_cnn_w, wr_data_cnn_w, rows_written, cyc});
        if (m != 3'd0 && (wr_en_fc_w || wr_addr_fc_w != 16'h0 || wr_data_fc_w != 64'h0)) bad_unsel++;
        if (m != 3'd1 && (wr_en_cnn_w || wr_addr_cnn_w != 16'h0 || wr_data_cnn_w != 64'h0)) bad_unsel++;
        if (done) begin
            done_cyc_q.push_back(cyc);
            if (busy) busy_at_done++;
            if (s_ready) ready_at_done++;
        end
    endtask

    // Issue a start, then feed beat_q while s_ready is high; abort rides with beat abort_at.
    task automatic drive_load(input logic [2:0] m, input logic [15:0] base, input logic [15:0] n,
                              input int valid_pct, input int abort_at, input bit abort_on_start);
        int hs;
        int k;
        hs = 0;
        k  = 0;
        obs_q.delete(); hi_cyc_q.delete(); done_cyc_q.delete();
        ready_seen = 0; bad_unsel = 0; busy_at_done = 0; ready_at_done = 0; timed_out = 0;
        mode = m; base_addr = base; num_rows = n; start = 1'b1; abort = abort_on_start;
        start_cyc = cyc;
        step(m);
        start = 1'b0; abort = 1'b0;
        mode = 3'($urandom); base_addr = 16'($urandom); num_rows = 16'($urandom);
        while (s_ready && k < 2000) begin
            if (hs == abort_at) begin
                abort   = 1'b1;
                s_valid = 1'b1;
            end else begin
                s_valid = (int'($urandom_range(99)) < valid_pct);
            end
            s_data = s_valid ? beat_q[hs] : 32'($urandom);
            if (s_valid) begin
                if (hs % 2 == 1 && hs != abort_at) hi_cyc_q.push_back(cyc);
                hs++;
            end
            step(m);
            abort = 1'b0; s_valid = 1'b0; k++;
        end
        if (k >= 2000) timed_out = 1'b1;
        repeat (3) step(m);
    endtask

    // Complete load scenario: every row, address, port, latency and the done pulse.
    task automatic test_full_load(input logic [2:0] m, input logic [15:0] base, input logic [15:0] n,
                                  input int valid_pct, input bit abort_on_start);
        logic [15:0] exp_addr;
        logic [63:0] exp_data;
        int          last_cyc;
        drive_load(m, base, n, valid_pct, -1, abort_on_start);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL load_timeout: s_ready still high after 2000 cycles (required low)"); end
        n_checks++;
        if (obs_q.size() != int'(n)) begin n_fail++; $display("FAIL write_count: got %0d writes, required %0d", obs_q.size(), n); end
        for (int i = 0; i < obs_q.size() && i < int'(n); i++) begin
            exp_addr = base + 16'(i);
            exp_data = {beat_q[2*i+1], beat_q[2*i]};
            n_checks++;
            if (obs_q[i].cnn !== m[0] || obs_q[i].addr !== exp_addr || obs_q[i].data !== exp_data) begin
                n_fail++;
                $display("FAIL row%0d: got cnn=%0b addr=%h data=%h, required cnn=%0b addr=%h data=%h",
                         i, obs_q[i].cnn, obs_q[i].addr, obs_q[i].data, m[0], exp_addr, exp_data);
            end
            n_checks++;
            if (i >= hi_cyc_q.size() || obs_q[i].cyc != hi_cyc_q[i] + 1) begin
                n_fail++; $display("FAIL latency_row%0d: strobe at cycle %0d, high beat at %0d", i, obs_q[i].cyc,
                                   (i < hi_cyc_q.size()) ? hi_cyc_q[i] : -1);
            end
            n_checks++;
            if (obs_q[i].rw !== 16'(i + 1)) begin
                n_fail++; $display("FAIL rows_written_at_strobe%0d: got %0d, required %0d", i, obs_q[i].rw, i + 1);
            end
        end
        last_cyc = (obs_q.size() > 0) ? obs_q[obs_q.size()-1].cyc : -1;
        n_checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != last_cyc) begin
            n_fail++; $display("FAIL done_timing: %0d pulses, first at %0d, required 1 at %0d", done_cyc_q.size(),
                               (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, last_cyc);
        end
        n_checks++;
        if (busy_at_done != 0 || ready_at_done != 0) begin
            n_fail++; $display("FAIL busy_ready_at_done: busy=%0d ready=%0d, required 0 0", busy_at_done, ready_at_done);
        end
        n_checks++;
        if (bad_unsel != 0) begin n_fail++; $display("FAIL unselected_port: %0d nonzero cycles, required 0", bad_unsel); end
        n_checks++;
        if (rows_written !== n) begin n_fail++; $display("FAIL rows_written_final: got %0d, required %0d", rows_written, n); end
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({s_ready, wr_en_fc_w, wr_addr_fc_w, wr_data_fc_w, wr_en_cnn_w, wr_addr_cnn_w, wr_data_cnn_w,
             busy, done, rows_written} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: outputs not all zero during reset (required zero)");
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) step(3'd7);
        n_checks++;
        if ({s_ready, busy, done, rows_written} !== '0) begin
            n_fail++; $display("FAIL post_reset_idle: ready=%0b busy=%0b done=%0b rw=%0d, required all 0",
                               s_ready, busy, done, rows_written);
        end
    endtask

    task automatic test_fc_load();
        beat_q.delete();
        for (int i = 0; i < 8; i++) beat_q.push_back(32'h03020100 + 32'(i) * 32'h04040404);
        test_full_load(3'd0, 16'h0010, 16'd3, 100, 1'b0);
        n_checks++;
        if (obs_q.size() < 1 || obs_q[0].data !== 64'h0706050403020100) begin
            n_fail++; $display("FAIL fc_first_row: got %h, required 0706050403020100",
                               (obs_q.size() > 0) ? obs_q[0].data : 64'h0);
        end
    endtask

    task automatic test_cnn_stall();
        fill_beats(8);
        test_full_load(3'd1, 16'h8000, 16'd2, 50, 1'b0);
    endtask

    task automatic test_wrap();
        fill_beats(8);
        // abort held with start: no effect while idle
        test_full_load(3'($urandom_range(1)), 16'hFFFF, 16'd2, 100, 1'b1);
        n_checks++;
        if (obs_q.size() < 2 || obs_q[1].addr !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_addr: second row address wrong, required 0000");
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = int'($urandom_range(8, 5));
        fill_beats(2 * n + 4);
        test_full_load(3'($urandom_range(1)), 16'($urandom), 16'(n), 100, 1'b0);
        for (int i = 1; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].cyc - obs_q[i-1].cyc != 2) begin
                n_fail++; $display("FAIL b2b_spacing%0d: got %0d cycles, required 2", i, obs_q[i].cyc - obs_q[i-1].cyc);
            end
        end
    endtask

    task automatic test_random_loads();
        int n;
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(8, 1));
            fill_beats(2 * n + 4);
            test_full_load(3'($urandom_range(1)), 16'($urandom), 16'(n), int'($urandom_range(100, 40)), 1'b0);
        end
    endtask

    task automatic test_zero_illegal();
        logic [2:0]  m;
        logic [15:0] n;
        for (int c = 0; c < 8; c++) begin
            m = (c < 2) ? 3'(c) : 3'(c);
            n = (c < 2) ? 16'd0 : 16'($urandom_range(20, 1));
            fill_beats(48);
            drive_load(m, 16'($urandom), n, 100, -1, 1'b0);
            n_checks++;
            if (obs_q.size() != 0 || bad_unsel != 0) begin
                n_fail++; $display("FAIL no_write_case%0d: %0d writes, %0d port cycles nonzero, required 0 0", c, obs_q.size(), bad_unsel);
            end
            n_checks++;
            if (done_cyc_q.size() != 1 || done_cyc_q[0] != start_cyc + 1) begin
                n_fail++; $display("FAIL no_load_done%0d: %0d pulses, required one at start+1", c, done_cyc_q.size());
            end
            n_checks++;
            if (ready_seen != 0 || rows_written !== 16'd0) begin
                n_fail++; $display("FAIL no_load_ready%0d: ready cycles=%0d rw=%0d, required 0 0", c, ready_seen, rows_written);
            end
        end
    endtask

    task automatic test_abort();
        logic [2:0] m;
        m = 3'($urandom_range(1));
        // abort with the 4th beat: row 0 written, row 1 never
        fill_beats(12);
        drive_load(m, 16'($urandom), 16'd4, 100, 3, 1'b0);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0].data !== {beat_q[1], beat_q[0]}) begin
            n_fail++; $display("FAIL abort_writes: got %0d writes, required 1 with row 0 data", obs_q.size());
        end
        n_checks++;
        if (done_cyc_q.size() != 0 || rows_written !== 16'd1 || s_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: done=%0d rw=%0d ready=%0b busy=%0b, required 0 1 0 0",
                               done_cyc_q.size(), rows_written, s_ready, busy);
        end
        // abort coinciding with the final high beat: abort wins
        fill_beats(8);
        drive_load(m, 16'($urandom), 16'd2, 100, 3, 1'b0);
        n_checks++;
        if (obs_q.size() != 1 || done_cyc_q.size() != 0 || rows_written !== 16'd1) begin
            n_fail++; $display("FAIL abort_final_beat: writes=%0d done=%0d rw=%0d, required 1 0 1",
                               obs_q.size(), done_cyc_q.size(), rows_written);
        end
        fill_beats(6);
        test_full_load(3'($urandom_range(1)), 16'($urandom), 16'd1, 100, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        fill_beats(8);
        mode = 3'd0; base_addr = 16'h0100; num_rows = 16'd3; start = 1'b1;
        step(3'd0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = beat_q[i];
            step(3'd0);
        end
        s_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || rows_written !== 16'd1) begin
            n_fail++; $display("FAIL pre_reset_load: busy=%0b rw=%0d, required 1 1", busy, rows_written);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({s_ready, wr_en_fc_w, wr_addr_fc_w, wr_data_fc_w, wr_en_cnn_w, wr_addr_cnn_w, wr_data_cnn_w,
             busy, done, rows_written} !== '0) begin
            n_fail++; $display("FAIL mid_load_reset: outputs not zero immediately (busy=%0b rw=%0d ready=%0b)",
                               busy, rows_written, s_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        fill_beats(6);
        test_full_load(3'd0, 16'h0200, 16'd1, 100, 1'b0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 3'd0; base_addr = 16'h0;
        num_rows = 16'h0; s_valid = 1'b0; s_data = 32'h0;
        cyc = 0; n_checks = 0; n_fail = 0;
        test_reset();
        test_fc_load();
        test_cnn_stall();
        test_wrap();
        test_back_to_back();
        test_zero_illegal();
        test_abort();
        test_reset_mid_load();
        test_random_loads();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
